// File: rtl/seg7_scan_driver_pkg.sv
// Shared definitions for the seven-segment scan driver: FSM and digit-index
// encodings, segment patterns ([0]=a .. [6]=g, [7]=dp) and small helpers.
package seg7_scan_driver_pkg;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_CONVERT = 1'b1
  } conv_state_t;

  typedef enum logic [1:0] {
    DIG_UNITS    = 2'd0,
    DIG_TENS     = 2'd1,
    DIG_HUNDREDS = 2'd2
  } digit_idx_t;

  localparam logic [0:7] SEG_0     = 8'b1111_1100;
  localparam logic [0:7] SEG_1     = 8'b0110_0000;
  localparam logic [0:7] SEG_2     = 8'b1101_1010;
  localparam logic [0:7] SEG_3     = 8'b1111_0010;
  localparam logic [0:7] SEG_4     = 8'b0110_0110;
  localparam logic [0:7] SEG_5     = 8'b1011_0110;
  localparam logic [0:7] SEG_6     = 8'b1011_1110;
  localparam logic [0:7] SEG_7     = 8'b1110_0000;
  localparam logic [0:7] SEG_8     = 8'b1111_1110;
  localparam logic [0:7] SEG_9     = 8'b1111_0110;
  localparam logic [0:7] SEG_BLANK = 8'b0000_0000;

  function automatic logic [0:7] seg_encode(input logic [3:0] digit);
    logic [0:7] seg;
    case (digit)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] add3_if_ge5(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

endpackage

// File: rtl/seg7_scan_driver_bin2bcd_seq.sv
// Handshaked sequential binary-to-BCD converter (shift-add-3, one bit per clock).
// bcd is meaningful only while bcd_load is high; the consumer latches it then.
module bin2bcd_seq
  import seg7_scan_driver_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  number8bits,
  input  logic        num_valid,
  output logic        num_ready,
  output logic        busy,
  output logic [11:0] bcd,
  output logic        bcd_load
);

  conv_state_t r_state, w_state_nxt;
  logic [19:0] r_shift, w_shift_nxt;
  logic [19:0] w_adj, w_shifted;
  logic [2:0]  r_iter, w_iter_nxt;
  logic        r_out_of_rst;

  assign w_adj     = {add3_if_ge5(r_shift[19:16]), add3_if_ge5(r_shift[15:12]),
                      add3_if_ge5(r_shift[11:8]), r_shift[7:0]};
  assign w_shifted = w_adj << 1;

  // Ready stays low through the first edge after reset is released.
  assign num_ready = (r_state == ST_IDLE) && r_out_of_rst;
  assign busy      = (r_state == ST_CONVERT);
  assign bcd       = w_shifted[19:8];

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_iter_nxt  = r_iter;
    bcd_load    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (num_valid && num_ready) begin
          w_shift_nxt = {12'b0, number8bits};
          w_iter_nxt  = '0;
          w_state_nxt = ST_CONVERT;
        end
      end
      ST_CONVERT: begin
        w_shift_nxt = w_shifted;
        w_iter_nxt  = r_iter + 3'd1;
        if (r_iter == 3'd7) begin
          bcd_load    = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state      <= ST_IDLE;
      r_shift      <= '0;
      r_iter       <= '0;
      r_out_of_rst <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_shift      <= w_shift_nxt;
      r_iter       <= w_iter_nxt;
      r_out_of_rst <= 1'b1;
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Converts an 8-bit value to three BCD digits and time-multiplexes them onto
// one segment bus with leading-zero blanking and optional active-low outputs.
module seg7_scan_driver
  import seg7_scan_driver_pkg::*;
#(
  parameter int unsigned SCAN_DIV   = 1000,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] number8bits,
  input  logic       num_valid,
  output logic       num_ready,
  output logic       busy,
  output logic [0:7] display,
  output logic [2:0] digit_en
);

  localparam int unsigned     CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [0:7]      SEG_POL  = {8{ACTIVE_LOW}};
  localparam logic [2:0]      DEN_POL  = {3{ACTIVE_LOW}};

  logic [CNT_W-1:0] r_scan_cnt;
  logic             w_tick;
  digit_idx_t       r_digit_idx, w_digit_nxt;
  logic [11:0]      r_bcd;
  logic [11:0]      w_bcd_new;
  logic             w_bcd_load;
  logic [0:7]       w_seg_nxt;
  logic [2:0]       w_den_nxt;
  logic [0:7]       r_display;
  logic [2:0]       r_digit_en;

  bin2bcd_seq u_conv (
    .clk         (clk),
    .reset_n     (reset_n),
    .number8bits (number8bits),
    .num_valid   (num_valid),
    .num_ready   (num_ready),
    .busy        (busy),
    .bcd         (w_bcd_new),
    .bcd_load    (w_bcd_load)
  );

  assign w_tick   = (r_scan_cnt == CNT_LAST);
  assign display  = r_display;
  assign digit_en = r_digit_en;

  always_comb begin
    w_digit_nxt = DIG_UNITS;
    case (r_digit_idx)
      DIG_UNITS: w_digit_nxt = DIG_TENS;
      DIG_TENS:  w_digit_nxt = DIG_HUNDREDS;
      default:   w_digit_nxt = DIG_UNITS;
    endcase
  end

  // Segment pattern for the digit about to be enabled, with leading-zero blanking.
  always_comb begin
    w_den_nxt = 3'b001;
    w_seg_nxt = SEG_BLANK;
    case (w_digit_nxt)
      DIG_UNITS: begin
        w_den_nxt = 3'b001;
        w_seg_nxt = seg_encode(r_bcd[3:0]);
      end
      DIG_TENS: begin
        w_den_nxt = 3'b010;
        if (r_bcd[11:4] != 8'd0)
          w_seg_nxt = seg_encode(r_bcd[7:4]);
      end
      DIG_HUNDREDS: begin
        w_den_nxt = 3'b100;
        if (r_bcd[11:8] != 4'd0)
          w_seg_nxt = seg_encode(r_bcd[11:8]);
      end
      default: begin
        w_den_nxt = 3'b001;
        w_seg_nxt = SEG_BLANK;
      end
    endcase
  end

  // A tick on the latch edge still samples the old r_bcd, so digits never mix values.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_scan_cnt  <= '0;
      r_digit_idx <= DIG_UNITS;
      r_bcd       <= '0;
      r_display   <= SEG_0 ^ SEG_POL;
      r_digit_en  <= 3'b001 ^ DEN_POL;
    end else begin
      r_scan_cnt <= w_tick ? '0 : r_scan_cnt + 1'b1;
      if (w_bcd_load)
        r_bcd <= w_bcd_new;
      if (w_tick) begin
        r_digit_idx <= w_digit_nxt;
        r_display   <= w_seg_nxt ^ SEG_POL;
        r_digit_en  <= w_den_nxt ^ DEN_POL;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: reset, conversions, busy handling,
// blanking, mid-conversion reset and an active-low fast-scan instance.
module tb_seg7_scan_driver;

  logic       clk;
  logic       reset_n;
  logic [7:0] number8bits;
  logic       num_valid;
  logic       num_ready;
  logic       busy;
  logic [0:7] display;
  logic [2:0] digit_en;

  logic       num_ready2;
  logic       busy2;
  logic [0:7] display2;
  logic [2:0] digit_en2;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  seg7_scan_driver #(.SCAN_DIV(4), .ACTIVE_LOW(1'b0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .number8bits (number8bits),
    .num_valid   (num_valid),
    .num_ready   (num_ready),
    .busy        (busy),
    .display     (display),
    .digit_en    (digit_en)
  );

  seg7_scan_driver #(.SCAN_DIV(2), .ACTIVE_LOW(1'b1)) dut_al (
    .clk         (clk),
    .reset_n     (reset_n),
    .number8bits (8'd0),
    .num_valid   (1'b0),
    .num_ready   (num_ready2),
    .busy        (busy2),
    .display     (display2),
    .digit_en    (digit_en2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Hand-derived patterns, MSB = segment a, LSB = dp.
  function automatic logic [7:0] seg_tab(input logic [3:0] d);
    case (d)
      4'd0: return 8'b1111_1100;
      4'd1: return 8'b0110_0000;
      4'd2: return 8'b1101_1010;
      4'd3: return 8'b1111_0010;
      4'd4: return 8'b0110_0110;
      4'd5: return 8'b1011_0110;
      4'd6: return 8'b1011_1110;
      4'd7: return 8'b1110_0000;
      4'd8: return 8'b1111_1110;
      4'd9: return 8'b1111_0110;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] exp_seg(input logic [11:0] b, input logic [2:0] den);
    case (den)
      3'b001:  return seg_tab(b[3:0]);
      3'b010:  return (b[11:4] == 8'd0) ? 8'h00 : seg_tab(b[7:4]);
      3'b100:  return (b[11:8] == 4'd0) ? 8'h00 : seg_tab(b[11:8]);
      default: return 8'hEE;
    endcase
  endfunction

  function automatic logic [2:0] rot1(input logic [2:0] x);
    return {x[1:0], x[2]};
  endfunction

  task automatic wait_tick(input int unsigned budget, output logic ok);
    logic [2:0] prev;
    prev = digit_en;
    ok = 1'b0;
    for (int i = 0; i < int'(budget) && !ok; i++) begin
      @(negedge clk);
      if (digit_en !== prev) ok = 1'b1;
    end
  endtask

  // Follows three scan ticks and checks each digit against the expected BCD.
  task automatic check_scan(input string tag, input logic [11:0] b);
    logic [2:0] seen;
    logic [2:0] prev;
    logic       ok;
    seen = 3'b000;
    for (int k = 0; k < 3; k++) begin
      prev = digit_en;
      wait_tick(8, ok);
      check_eq({tag, "_tick"}, {31'b0, ok}, 32'd1);
      if (ok) begin
        seen = seen | digit_en;
        check_eq({tag, "_rot"}, {29'b0, digit_en}, {29'b0, rot1(prev)});
        check_eq({tag, "_seg"}, {24'b0, display}, {24'b0, exp_seg(b, digit_en)});
      end
    end
    check_eq({tag, "_cover"}, {29'b0, seen}, 32'h7);
  endtask

  task automatic convert(input string tag, input logic [7:0] val, input logic [11:0] exp_bcd);
    int unsigned n_busy;
    @(negedge clk);
    check_eq({tag, "_ready"}, {31'b0, num_ready}, 32'd1);
    number8bits = val;
    num_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    num_valid = 1'b0;
    n_busy = 0;
    for (int i = 0; i < 12; i++) begin
      if (busy === 1'b1) n_busy++;
      @(negedge clk);
    end
    check_eq({tag, "_busycycles"}, n_busy, 32'd8);
    check_eq({tag, "_bcd"}, {20'b0, dut.r_bcd}, {20'b0, exp_bcd});
    check_eq({tag, "_idle"}, {30'b0, busy, num_ready}, 32'b01);
  endtask

  initial begin
    logic [2:0] prev2;
    logic       ok2;

    reset_n     = 1'b0;
    number8bits = 8'd0;
    num_valid   = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_digit_en", {29'b0, digit_en}, 32'b001);
    check_eq("rst_display", {24'b0, display}, 32'b1111_1100);
    check_eq("rst_ready", {31'b0, num_ready}, 32'd0);
    check_eq("rst_busy", {31'b0, busy}, 32'd0);
    check_eq("rst_al_digit_en", {29'b0, digit_en2}, 32'b110);
    check_eq("rst_al_display", {24'b0, display2}, 32'b0000_0011);

    reset_n = 1'b1;
    #1;
    check_eq("rel_ready_now", {31'b0, num_ready}, 32'd0);
    @(negedge clk);
    check_eq("rel_ready_next", {31'b0, num_ready}, 32'd1);

    // Active-low instance: each digit held exactly 2 clocks, inverted outputs.
    for (int k = 0; k < 3; k++) begin
      prev2 = digit_en2;
      ok2 = 1'b0;
      for (int i = 0; i < 4 && !ok2; i++) begin
        @(negedge clk);
        if (digit_en2 !== prev2) ok2 = 1'b1;
      end
      check_eq("al_tick", {31'b0, ok2}, 32'd1);
      check_eq("al_rot", {29'b0, digit_en2}, {29'b0, ~rot1(~prev2)});
      check_eq("al_seg", {24'b0, display2},
               (digit_en2 == 3'b110) ? 32'b0000_0011 : 32'hFF);
      prev2 = digit_en2;
      @(negedge clk);
      check_eq("al_hold", {29'b0, digit_en2}, {29'b0, prev2});
    end

    convert("c255", 8'd255, 12'h255);
    check_scan("s255", 12'h255);

    convert("c7", 8'd7, 12'h007);
    check_scan("s7", 12'h007);

    // 100 accepted, 42 offered from T+3 and held until accepted.
    @(negedge clk);
    check_eq("c100_ready", {31'b0, num_ready}, 32'd1);
    number8bits = 8'd100;
    num_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    num_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    number8bits = 8'd42;
    num_valid   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check_eq("c42_blocked", {30'b0, num_ready, busy}, 32'b01);
      @(negedge clk);
    end
    check_eq("c100_done_ready", {30'b0, num_ready, busy}, 32'b10);
    check_eq("c100_bcd", {20'b0, dut.r_bcd}, 32'h100);
    @(negedge clk);
    check_eq("c42_accepted", {31'b0, busy}, 32'd1);
    num_valid = 1'b0;
    repeat (12) @(negedge clk);
    check_eq("c42_bcd", {20'b0, dut.r_bcd}, 32'h042);
    check_scan("s42", 12'h042);

    // Reset at T+4 of converting 200 must discard the conversion.
    @(negedge clk);
    number8bits = 8'd200;
    num_valid   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    num_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check_eq("r200_bcd", {20'b0, dut.r_bcd}, 32'h000);
    check_eq("r200_state", {31'b0, dut.u_conv.r_state}, 32'd0);
    check_eq("r200_busy", {31'b0, busy}, 32'd0);
    check_eq("r200_display", {24'b0, display}, 32'b1111_1100);
    check_eq("r200_digit_en", {29'b0, digit_en}, 32'b001);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check_eq("r200_bcd_after", {20'b0, dut.r_bcd}, 32'h000);
    check_scan("s200rst", 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
